// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES slices,
// one slice per register stage, each slice built from GROUP-bit lookahead groups.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int GROUP  = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;

    // Returns {carry_out, sum} for one slice; bits ripple inside a group, groups chain via group P/G.
    function automatic logic [SW:0] slice_add(input logic [SW-1:0] a,
                                               input logic [SW-1:0] b,
                                               input logic          cin);
        logic [SW-1:0] g, p, s;
        logic          c, bc, gg, gp;
        int            idx;
        g = a & b;
        p = a ^ b;
        s = '0;
        c = cin;
        for (int grp = 0; grp < NG; grp++) begin
            bc = c;
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                idx    = grp * GROUP + i;
                s[idx] = p[idx] ^ bc;
                bc     = g[idx] | (p[idx] & bc);
                gg     = g[idx] | (p[idx] & gg);
                gp     = gp & p[idx];
            end
            c = gg | (gp & c);
        end
        return {c, s};
    endfunction

    logic [WIDTH-1:0] b_ent;
    logic             c_ent;

    // sbb: in_cin=1 means a borrow is pending, so the carry-in is its complement.
    always_comb begin
        b_ent = in_op[0] ? ~in_b : in_b;
        case (in_op)
            2'b00:   c_ent = 1'b0;
            2'b01:   c_ent = 1'b1;
            2'b10:   c_ent = in_cin;
            default: c_ent = ~in_cin;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * SW;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]      a_i, b_i;
        logic               c_i, v_i;
        logic [TAG_W-1:0]   tag_i;
        logic [LO+SW-1:0]   res_n, res_q;
        logic [SW:0]        sr;
        logic               v_q, c_q, rdy, load;
        logic [TAG_W-1:0]   tag_q;

        if (k == 0) begin : g_in
            assign a_i   = in_a;
            assign b_i   = b_ent;
            assign c_i   = c_ent;
            assign v_i   = in_valid;
            assign tag_i = in_tag;
            assign res_n = sr[SW-1:0];
        end else begin : g_in
            assign a_i   = stg[k-1].g_fwd.a_q;
            assign b_i   = stg[k-1].g_fwd.b_q;
            assign c_i   = stg[k-1].c_q;
            assign v_i   = stg[k-1].v_q;
            assign tag_i = stg[k-1].tag_q;
            assign res_n = {sr[SW-1:0], stg[k-1].res_q};
        end

        assign sr = slice_add(a_i[SW-1:0], b_i[SW-1:0], c_i);

        if (k == STAGES - 1) begin : g_rdy
            assign rdy = ~v_q | out_ready;
        end else begin : g_rdy
            assign rdy = ~v_q | stg[k+1].rdy;
        end

        assign load = rdy & v_i;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
                tag_q <= '0;
            end else begin
                if (rdy) v_q <= v_i;
                if (load) begin
                    res_q <= res_n;
                    c_q   <= sr[SW];
                    tag_q <= tag_i;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Only the operand bits still to be summed travel on to later stages.
            logic [RW-SW-1:0] a_q, b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_i[RW-1:SW];
                    b_q <= b_i[RW-1:SW];
                end
            end
        end else begin : g_flags
            logic ovf_q, zero_q, neg_q;
            // Carry into the MSB is recovered as sum ^ a ^ b' at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                end else if (load) begin
                    ovf_q  <= sr[SW] ^ sr[SW-1] ^ a_i[SW-1] ^ b_i[SW-1];
                    zero_q <= ~|res_n;
                    neg_q  <= res_n[LO+SW-1];
                end
            end
        end
    end

    assign in_ready  = stg[0].rdy;
    assign out_valid = stg[STAGES-1].v_q;
    assign out_res   = stg[STAGES-1].res_q;
    assign out_cout  = stg[STAGES-1].c_q;
    assign out_tag   = stg[STAGES-1].tag_q;
    assign out_ovf   = stg[STAGES-1].g_flags.ovf_q;
    assign out_zero  = stg[STAGES-1].g_flags.zero_q;
    assign out_neg   = stg[STAGES-1].g_flags.neg_q;

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the core's 32-bit combinational carry-lookahead adder. The carry chain is split across STAGES register stages, each built from GROUP-bit lookahead groups. It accepts one operation per cycle over a valid/ready handshake, returns status flags and a pass-through tag, and sits between the ALU operand latch and writeback in the execute path.

Parameters:
WIDTH, 32, operand/result width; must be divisible by STAGES*GROUP
STAGES, 4, number of pipeline register stages (1..8); latency in cycles when not stalled
GROUP, 4, bits per lookahead group inside each stage slice
TAG_W, 5, width of the side-band tag carried alongside each operation

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  2  00 add, 01 sub, 10 add-with-carry, 11 sub-with-borrow
in_cin  in  1  carry/borrow-in, used only by ops 10/11
in_tag  in  TAG_W  side-band tag, returned unchanged
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_res  out  WIDTH  sum/difference, modulo 2^WIDTH
out_cout  out  1  carry-out of MSB (for sub: 1 = no borrow)
out_ovf  out  1  signed overflow
out_zero  out  1  out_res == 0
out_neg  out  1  out_res[WIDTH-1]
out_tag  out  TAG_W  tag of the returned operation

Behaviour:
- Operand transform at entry:
  - add: b' = b, c0 = 0
  - sub: b' = ~b, c0 = 1
  - adc: b' = b, c0 = in_cin
  - sbb: b' = ~b, c0 = ~in_cin (in_cin = 1 means a borrow is pending)
- Slice k (width WIDTH/STAGES) is computed in stage k from the registered carry of stage k-1. Slice results for lower bits and the not-yet-used upper operand bits (a, b') are carried forward in the stage registers.
- Each slice uses GROUP-bit lookahead: generate/propagate per bit, group carry from group P/G, ripple between groups within the slice.
- Flags are computed in the last stage from the final result:
  - ovf = carry into MSB XOR carry out of MSB
  - zero and neg are derived from out_res
- Handshake: a transfer occurs when valid && ready on the same edge. Stage k holds valid_k. Ready chain is ready_k = ~valid_k | ready_{k+1}, with ready_STAGES = out_ready. in_ready = ready_0.
- Throughput is 1 op/cycle. Latency is exactly STAGES cycles from input acceptance to out_valid when out_ready is held at 1.
- Bubbles collapse: an empty stage accepts data even while a later stage is stalled.
- Stall: while out_valid && !out_ready, out_res/out_* and all stage contents hold stable. No operation is dropped or duplicated.
- Ordering is strictly FIFO; out_tag always matches the op that produced out_res.
- Reset (async assert, sync-release by upstream): all valid bits become 0. out_res, out_tag and all flags become 0. in_ready is 1 from the first cycle after release.
- Reset mid-operation: all in-flight ops are discarded; no output is produced for them.
- No state machine beyond per-stage valid bits. Stage datapath registers load only when that stage advances.
- Inputs are ignored when in_valid = 0. in_cin is ignored for op 00/01.
- Full condition: all STAGES valid and out_ready = 0 gives in_ready = 0. Upstream must hold its inputs stable until accepted.
- Simultaneous pop and push on a full pipe: when out_ready = 1, in_ready = 1 in the same cycle and both transfers occur.

Test Plan:
- Reset and basic add (WIDTH=32, STAGES=4, out_ready=1): add 0x0000_0005 + 0x0000_0003 with tag 7 -> 4 cycles later out_res=0x8, cout=0, ovf=0, zero=0, out_tag=7.
- Cross-slice carry and wrap: add 0xFFFF_FFFF + 0x1 -> out_res=0, cout=1, zero=1, ovf=0. Add 0x7FFF_FFFF + 0x1 -> 0x8000_0000, ovf=1, neg=1.
- Sub and borrow ops: sub 3 - 5 -> 0xFFFF_FFFE, cout=0, neg=1. sbb 10 - 3 with in_cin=1 -> 6. adc 0xFFFF_FFFF + 0 with in_cin=1 -> 0, cout=1.
- Back-pressure: stream 8 ops with tags 0..7 while holding out_ready=0 for 6 cycles -> in_ready drops after 4 accepts, outputs stay stable, then all 8 results emerge in tag order with no loss.
- Bubble collapse and simultaneous push/pop: alternate in_valid on/off with random out_ready -> output sequence matches a reference model; a push on a full pipe with out_ready=1 is accepted in the same cycle.
- Async reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately and all outputs 0; after release, no stale results appear and a new op completes in 4 cycles.
